mem_unit: RTL and testbench
===========================

MEM_UNIT -- requirements
Module: mem_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/data width.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning memory address width.
REQ-003 SHALL have parameter BUS_W, default 8, meaning RAM data port width; legal values are 8, 16 and 32.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port valid_i, input, 1, EX/MEM entry valid.
REQ-007 SHALL have port op_i, input, 4, access code: NONE, LB, LBU, LH, LHU, LW, SB, SH, SW.
REQ-008 SHALL have port addr_i, input, ADDR_W, byte address.
REQ-009 SHALL have ports w_addr_i (5), w_req_i (1) and w_data_i (XLEN), inputs, writeback info; w_data_i is also store data.
REQ-010 SHALL have ports w_addr_o (5), w_req_o (1) and w_data_o (XLEN), outputs, writeback to MEM/WB.
REQ-011 SHALL have ports mem_req_o (1), mem_we_o (1), mem_addr_o (ADDR_W) and mem_wdata_o (BUS_W), outputs, RAM request.
REQ-012 SHALL have ports mem_ack_i (1) and mem_rdata_i (BUS_W), inputs, RAM beat accepted/returned.
REQ-013 SHALL have port mem_stall_o, output, 1, freezes upstream pipeline.
REQ-014 SHALL have port misalign_o, output, 1, misaligned-access pulse (present only with MEM_MISALIGN_EN).

Function
REQ-015 SHALL treat NONE ops and valid_i=0 as pass-through: w_*_o = w_*_i combinationally, no RAM request, no stall.
REQ-016 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE.
REQ-017 In IDLE with valid_i=1 and a memory op, SHALL capture op, addr, store data and w_addr, clear the beat counter, assert mem_stall_o combinationally and go to ACCESS.
REQ-018 SHALL use size = 1/2/4 bytes for B/H/W ops and beats N = ceil(size/(BUS_W/8)).
REQ-019 In ACCESS, SHALL hold mem_req_o=1, mem_we_o=1 for stores and mem_addr_o = addr + beat*(BUS_W/8) stable until mem_ack_i=1.
REQ-020 Store beat k SHALL drive mem_wdata_o = store data bits [k*BUS_W +: BUS_W]; unused lanes of a partial beat SHALL be zero.
REQ-021 On each mem_ack_i, SHALL latch mem_rdata_i into result slot k, then increment beat, or go to DONE after beat N-1.
REQ-022 DONE SHALL last exactly one cycle, with mem_stall_o=0, mem_req_o=0 and w_data_o = assembled result: LB/LH sign-extended, LBU/LHU zero-extended, LW full; w_req_o = captured w_req for loads and 0 for stores.
REQ-023 mem_stall_o SHALL be 1 in IDLE-with-accepted-op and in ACCESS; otherwise 0.
REQ-024 With ack on first request cycle, LW at BUS_W=8 SHALL stall 5 cycles and deliver in cycle 6; at BUS_W=32 SHALL stall 2 and deliver in cycle 3.
REQ-025 mem_ack_i outside ACCESS SHALL be ignored.
REQ-026 Inputs SHALL be ignored while not in IDLE; upstream holds them stable while stalled.

Reset
REQ-027 On rst=0, SHALL go to IDLE immediately, with beat counter 0, mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0, mem_stall_o=0, misalign_o=0, w_req_o=0, w_addr_o=0 and w_data_o=0.
REQ-028 Reset during ACCESS SHALL drop mem_req_o asynchronously; a partial store is not rolled back.

Configuration
REQ-029 With MEM_MISALIGN_EN defined, an H op with addr[0]=1 or a W op with addr[1:0]!=0 SHALL produce no RAM request, pulse misalign_o for the single IDLE cycle with w_req_o=0 and no stall.
REQ-030 Without MEM_MISALIGN_EN, misalign_o SHALL be absent and misaligned accesses SHALL proceed per REQ-019 at the unaligned address.

Verification
REQ-031 BUS_W=8, LW addr=0x100, RAM bytes 0x78,0x56,0x34,0x12, ack immediate -> addresses 0x100..0x103, w_data_o=0x12345678 on cycle 6, stall 5 cycles.
REQ-032 BUS_W=16, LH addr=0x20, rdata=0x8001 -> one beat, w_data_o=0xFFFF8001; LHU -> 0x00008001.
REQ-033 BUS_W=8, SW addr=0x40, data=0xDEADBEEF, ack delayed 3 cycles per beat -> mem_wdata_o EF,BE,AD,DE held stable, mem_we_o=1, w_req_o=0 in DONE.
REQ-034 rst=0 asserted mid-ACCESS of LW -> mem_req_o and mem_stall_o fall same cycle; after release, new LB completes normally.
REQ-035 MEM_MISALIGN_EN, LW addr=0x102 -> misalign_o=1 for one cycle, mem_req_o never 1; without the macro, beats go to 0x102..0x105.
REQ-036 op=NONE, w_req_i=1, w_data_i=0x5 -> w_data_o=0x5 same cycle, no stall, no RAM request.

Source files
------------

// File: rtl/mem_unit_if.sv
// Byte-addressed RAM request/response bus between mem_unit (master) and the RAM (slave).
interface mem_unit_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BUS_W  = 8
);
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [BUS_W-1:0]  mem_wdata_o;
  logic              mem_ack_i;
  logic [BUS_W-1:0]  mem_rdata_i;

  modport master (
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i
  );

  modport slave (
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i
  );
endinterface

// File: rtl/mem_unit.sv
// Pipeline MEM stage: splits B/H/W loads and stores into BUS_W-wide RAM beats and stalls upstream.
// Op codes: NONE=0 LB=1 LBU=2 LH=3 LHU=4 LW=5 SB=6 SH=7 SW=8. Optional MEM_MISALIGN_EN adds misalign_o.
module mem_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned BUS_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [3:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [4:0]        w_addr_i,
  input  logic              w_req_i,
  input  logic [XLEN-1:0]   w_data_i,
  output logic [4:0]        w_addr_o,
  output logic              w_req_o,
  output logic [XLEN-1:0]   w_data_o,
  output logic              mem_stall_o,
`ifdef MEM_MISALIGN_EN
  output logic              misalign_o,
`endif
  mem_unit_if.master        mem
);
  localparam int unsigned BPB    = BUS_W / 8;
  localparam int unsigned SLOTS  = 32 / BUS_W;
  localparam int unsigned BEAT_W = 2;

  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [3:0]          op_q, op_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         sdata_q, sdata_d;
  logic [31:0]         result_q, result_d;
  logic [4:0]          waddr_q, waddr_d;
  logic                wreq_q, wreq_d;
  logic [BUS_W-1:0]    beat_wdata, lane_mask;
  logic                misaligned_c;

  function automatic logic [2:0] op_size(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic [BEAT_W-1:0] last_beat(input logic [2:0] size);
    return BEAT_W'((int'(size) + int'(BPB) - 1) / int'(BPB) - 1);
  endfunction

  function automatic logic [XLEN-1:0] extend(input logic [3:0] op, input logic [31:0] r);
    case (op)
      OP_LB:   return XLEN'($signed(r[7:0]));
      OP_LBU:  return XLEN'(r[7:0]);
      OP_LH:   return XLEN'($signed(r[15:0]));
      OP_LHU:  return XLEN'(r[15:0]);
      default: return XLEN'(r);
    endcase
  endfunction

`ifdef MEM_MISALIGN_EN
  assign misaligned_c = ((op_size(op_i) == 3'd2) && addr_i[0]) ||
                        ((op_size(op_i) == 3'd4) && (addr_i[1:0] != 2'b00));
  // Single-cycle flag: the op is dropped in IDLE, never reaching ACCESS.
  assign misalign_o   = rst && (state_q == S_IDLE) && valid_i &&
                        (op_size(op_i) != 3'd0) && misaligned_c;
`else
  assign misaligned_c = 1'b0;
`endif

  always_comb begin : next_state_outputs
    state_d  = state_q;
    beat_d   = beat_q;
    op_d     = op_q;
    addr_d   = addr_q;
    sdata_d  = sdata_q;
    result_d = result_q;
    waddr_d  = waddr_q;
    wreq_d   = wreq_q;
    beat_wdata = '0;
    lane_mask  = '0;
    w_addr_o    = w_addr_i;
    w_req_o     = w_req_i;
    w_data_o    = w_data_i;
    mem_stall_o = 1'b0;
    mem.mem_req_o   = 1'b0;
    mem.mem_we_o    = 1'b0;
    mem.mem_addr_o  = '0;
    mem.mem_wdata_o = '0;

    case (state_q)
      S_IDLE: begin
        if (valid_i && (op_size(op_i) != 3'd0)) begin
          w_req_o = 1'b0;
          if (!misaligned_c) begin
            mem_stall_o = 1'b1;
            op_d     = op_i;
            addr_d   = addr_i;
            sdata_d  = w_data_i[31:0];
            waddr_d  = w_addr_i;
            wreq_d   = w_req_i;
            beat_d   = '0;
            result_d = '0;
            state_d  = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        mem_stall_o = 1'b1;
        w_req_o     = 1'b0;
        for (int k = 0; k < int'(SLOTS); k++) begin
          if (beat_q == BEAT_W'(k)) beat_wdata = sdata_q[k*BUS_W +: BUS_W];
        end
        // Lanes past the access size stay zero on a partial beat.
        for (int b = 0; b < int'(BPB); b++) begin
          if (int'(beat_q) * int'(BPB) + b < int'(op_size(op_q))) lane_mask[b*8 +: 8] = 8'hFF;
        end
        mem.mem_req_o  = 1'b1;
        mem.mem_we_o   = is_store(op_q);
        mem.mem_addr_o = addr_q + ADDR_W'(int'(beat_q) * int'(BPB));
        if (is_store(op_q)) mem.mem_wdata_o = beat_wdata & lane_mask;
        if (mem.mem_ack_i) begin
          for (int k = 0; k < int'(SLOTS); k++) begin
            if (beat_q == BEAT_W'(k)) result_d[k*BUS_W +: BUS_W] = mem.mem_rdata_i;
          end
          if (beat_q == last_beat(op_size(op_q))) state_d = S_DONE;
          else                                    beat_d  = beat_q + BEAT_W'(1);
        end
      end
      S_DONE: begin
        w_addr_o = waddr_q;
        w_req_o  = wreq_q && !is_store(op_q);
        w_data_o = extend(op_q, result_q);
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs go quiet the instant reset asserts, not at the next edge.
    if (!rst) begin
      w_addr_o        = '0;
      w_req_o         = 1'b0;
      w_data_o        = '0;
      mem_stall_o     = 1'b0;
      mem.mem_req_o   = 1'b0;
      mem.mem_we_o    = 1'b0;
      mem.mem_addr_o  = '0;
      mem.mem_wdata_o = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin : state_regs
    if (!rst) begin
      state_q  <= S_IDLE;
      beat_q   <= '0;
      op_q     <= '0;
      addr_q   <= '0;
      sdata_q  <= '0;
      result_q <= '0;
      waddr_q  <= '0;
      wreq_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      sdata_q  <= sdata_d;
      result_q <= result_d;
      waddr_q  <= waddr_d;
      wreq_q   <= wreq_d;
    end
  end
endmodule

// File: tb/tb_mem_unit.sv
// Bench for mem_unit: BUS_W=8 instance run from a vector table against a RAM model with
// programmable ack latency and a per-beat scoreboard, plus a BUS_W=16 instance for width cases.
`timescale 1ns/1ps
module tb_mem_unit;
  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LB   = 4'd1;
  localparam logic [3:0] OP_LBU  = 4'd2;
  localparam logic [3:0] OP_LH   = 4'd3;
  localparam logic [3:0] OP_LHU  = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SB   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wreq;
    int          delay;
    logic [31:0] exp_data;
    logic        exp_wreq;
  } vec_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        valid_i, valid16;
  logic [3:0]  op_i;
  logic [31:0] addr_i;
  logic [4:0]  w_addr_i;
  logic        w_req_i;
  logic [31:0] w_data_i;
  logic [4:0]  w_addr_o, w_addr16;
  logic        w_req_o, w_req16;
  logic [31:0] w_data_o, w_data16;
  logic        stall_o, stall16;
`ifdef MEM_MISALIGN_EN
  logic        mis8, mis16;
`endif

  mem_unit_if #(.ADDR_W(32), .BUS_W(8))  bus8();
  mem_unit_if #(.ADDR_W(32), .BUS_W(16)) bus16();

  mem_unit #(.XLEN(32), .ADDR_W(32), .BUS_W(8)) u8 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .addr_i(addr_i),
    .w_addr_i(w_addr_i), .w_req_i(w_req_i), .w_data_i(w_data_i),
    .w_addr_o(w_addr_o), .w_req_o(w_req_o), .w_data_o(w_data_o),
    .mem_stall_o(stall_o),
`ifdef MEM_MISALIGN_EN
    .misalign_o(mis8),
`endif
    .mem(bus8)
  );

  mem_unit #(.XLEN(32), .ADDR_W(32), .BUS_W(16)) u16 (
    .clk(clk), .rst(rst), .valid_i(valid16), .op_i(op_i), .addr_i(addr_i),
    .w_addr_i(w_addr_i), .w_req_i(w_req_i), .w_data_i(w_data_i),
    .w_addr_o(w_addr16), .w_req_o(w_req16), .w_data_o(w_data16),
    .mem_stall_o(stall16),
`ifdef MEM_MISALIGN_EN
    .misalign_o(mis16),
`endif
    .mem(bus16)
  );

  logic [7:0] ram [0:511];
  beat_t      beat_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         ack_delay = 0;
  int         wcnt = 0;
  logic       ack8 = 1'b0;
  logic [7:0] rdata8 = 8'h00;
  vec_t       vecs [12];

  assign bus8.mem_ack_i    = ack8;
  assign bus8.mem_rdata_i  = rdata8;
  assign bus16.mem_ack_i   = bus16.mem_req_o;
  assign bus16.mem_rdata_i = {ram[bus16.mem_addr_o[8:0] + 9'd1], ram[bus16.mem_addr_o[8:0]]};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int sz(input logic [3:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic logic is_st(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // RAM model for the 8-bit port: checks every request cycle against the expected beat, acks after ack_delay waits.
  always @(negedge clk) begin
    if (bus8.mem_req_o) begin
      if (beat_q.size() == 0) begin
        chk("beat_unexpected", 32'(bus8.mem_addr_o), 32'hFFFF_FFFF);
        ack8 = 1'b0;
      end else begin
        chk("beat_addr", bus8.mem_addr_o, beat_q[0].addr);
        chk("beat_we", 32'(bus8.mem_we_o), 32'(beat_q[0].we));
        if (beat_q[0].we) chk("beat_wdata", 32'(bus8.mem_wdata_o), 32'(beat_q[0].wdata));
        if (wcnt == ack_delay) begin
          ack8   = 1'b1;
          wcnt   = 0;
          rdata8 = ram[bus8.mem_addr_o[8:0]];
          if (bus8.mem_we_o) ram[bus8.mem_addr_o[8:0]] = bus8.mem_wdata_o;
          void'(beat_q.pop_front());
        end else begin
          ack8 = 1'b0;
          wcnt++;
        end
      end
    end else begin
      ack8 = 1'b0;
      wcnt = 0;
    end
  end

  task automatic push_beats(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    d = data;
    for (int k = 0; k < sz(op); k++) beat_q.push_back('{is_st(op), addr + 32'(k), d[k*8 +: 8]});
  endtask

  task automatic run8(input vec_t v, input string tag);
    int stalls;
    bit done;
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = v.op; addr_i = v.addr; w_data_i = v.data;
    w_req_i = v.wreq; w_addr_i = 5'd17; ack_delay = v.delay;
    push_beats(v.op, v.addr, v.data);
    stalls = 0; done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (stall_o) stalls++;
      else         done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, "_stalls"}, 32'(stalls), 32'(1 + sz(v.op) * (v.delay + 1)));
      chk({tag, "_wreq"}, 32'(w_req_o), 32'(v.exp_wreq));
      chk({tag, "_memreq_done"}, 32'(bus8.mem_req_o), 32'd0);
      chk({tag, "_beats_left"}, 32'(beat_q.size()), 32'd0);
      if (!is_st(v.op)) begin
        chk({tag, "_wdata"}, w_data_o, v.exp_data);
        chk({tag, "_waddr"}, 32'(w_addr_o), 32'd17);
      end
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
    beat_q.delete();
  endtask

  task automatic run16(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                       input logic [31:0] exp, input int exp_stalls, input string tag);
    int stalls;
    bit done, first;
    logic [31:0] a0;
    logic [15:0] wd0;
    @(posedge clk); #1;
    valid16 = 1'b1; op_i = op; addr_i = addr; w_data_i = data; w_req_i = 1'b1; w_addr_i = 5'd9;
    stalls = 0; done = 1'b0; first = 1'b1; a0 = '0; wd0 = '0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (stall16) begin
        stalls++;
        if (first && bus16.mem_req_o) begin
          a0 = bus16.mem_addr_o; wd0 = bus16.mem_wdata_o; first = 1'b0;
        end
      end else done = 1'b1;
    end
    if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stalls));
      chk({tag, "_addr0"}, a0, addr);
      chk({tag, "_wreq"}, 32'(w_req16), 32'(!is_st(op)));
      if (is_st(op)) chk({tag, "_wdata0"}, 32'(wd0), exp);
      else begin
        chk({tag, "_wdata"}, w_data16, exp);
        chk({tag, "_waddr"}, 32'(w_addr16), 32'd9);
      end
    end
    @(posedge clk); #1;
    valid16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    ram[9'h100] = 8'h78; ram[9'h101] = 8'h56; ram[9'h102] = 8'h34; ram[9'h103] = 8'h12;
    ram[9'h020] = 8'h01; ram[9'h021] = 8'h80;

    vecs[0]  = '{OP_LW,  32'h100, 32'h0,        1'b1, 0, 32'h1234_5678, 1'b1};
    vecs[1]  = '{OP_SW,  32'h040, 32'hDEAD_BEEF, 1'b1, 3, 32'h0,         1'b0};
    vecs[2]  = '{OP_LW,  32'h040, 32'h0,        1'b1, 1, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{OP_LB,  32'h043, 32'h0,        1'b1, 0, 32'hFFFF_FFDE, 1'b1};
    vecs[4]  = '{OP_LBU, 32'h043, 32'h0,        1'b0, 0, 32'h0000_00DE, 1'b0};
    vecs[5]  = '{OP_LH,  32'h042, 32'h0,        1'b1, 0, 32'hFFFF_DEAD, 1'b1};
    vecs[6]  = '{OP_LHU, 32'h042, 32'h0,        1'b1, 2, 32'h0000_DEAD, 1'b1};
    vecs[7]  = '{OP_SH,  32'h050, 32'hCAFE_8001, 1'b1, 2, 32'h0,         1'b0};
    vecs[8]  = '{OP_LH,  32'h050, 32'h0,        1'b1, 0, 32'hFFFF_8001, 1'b1};
    vecs[9]  = '{OP_SB,  32'h060, 32'h1234_56A5, 1'b1, 0, 32'h0,         1'b0};
    vecs[10] = '{OP_LW,  32'h060, 32'h0,        1'b1, 0, 32'h0000_00A5, 1'b1};
    vecs[11] = '{OP_LB,  32'h041, 32'h0,        1'b1, 1, 32'hFFFF_FFBE, 1'b1};

    valid_i = 1'b0; valid16 = 1'b0; op_i = OP_NONE; addr_i = '0;
    w_req_i = 1'b1; w_data_i = 32'hABCD_1234; w_addr_i = 5'd3;

    // Reset state: outputs forced to zero even though pass-through inputs are live.
    #12;
    chk("rst_wreq", 32'(w_req_o), 32'd0);
    chk("rst_wdata", w_data_o, 32'd0);
    chk("rst_waddr", 32'(w_addr_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_memreq", 32'(bus8.mem_req_o), 32'd0);
    chk("rst_memaddr", bus8.mem_addr_o, 32'd0);
    chk("rst_memwe", 32'(bus8.mem_we_o), 32'd0);
    chk("rst_memwdata", 32'(bus8.mem_wdata_o), 32'd0);
    @(negedge clk); rst = 1'b1;

    // Pass-through for NONE and for valid_i=0 with a memory op.
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = OP_NONE; w_req_i = 1'b1; w_data_i = 32'h5; w_addr_i = 5'd4;
    #1;
    chk("pt_wdata", w_data_o, 32'h5);
    chk("pt_wreq", 32'(w_req_o), 32'd1);
    chk("pt_waddr", 32'(w_addr_o), 32'd4);
    chk("pt_stall", 32'(stall_o), 32'd0);
    chk("pt_memreq", 32'(bus8.mem_req_o), 32'd0);
    valid_i = 1'b0; op_i = OP_LW; w_data_i = 32'h77;
    #1;
    chk("inv_wdata", w_data_o, 32'h77);
    chk("inv_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    chk("inv_memreq", 32'(bus8.mem_req_o), 32'd0);

    for (int i = 0; i < 12; i++) run8(vecs[i], $sformatf("v%0d", i));

`ifdef MEM_MISALIGN_EN
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h102; w_req_i = 1'b1;
    #1;
    chk("mis_pulse", 32'(mis8), 32'd1);
    chk("mis_stall", 32'(stall_o), 32'd0);
    chk("mis_wreq", 32'(w_req_o), 32'd0);
    @(negedge clk);
    chk("mis_memreq", 32'(bus8.mem_req_o), 32'd0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    #1;
    chk("mis_pulse_end", 32'(mis8), 32'd0);
    @(negedge clk);
    chk("mis_memreq_after", 32'(bus8.mem_req_o), 32'd0);
`else
    run8('{OP_LW, 32'h102, 32'h0, 1'b1, 0, 32'h0000_1234, 1'b1}, "misal");
`endif

    // Reset in the middle of a slow LW, then a normal LB.
    @(posedge clk); #1;
    valid_i = 1'b1; op_i = OP_LW; addr_i = 32'h100; w_req_i = 1'b1; w_data_i = 32'hFFFF_FFFF;
    ack_delay = 3;
    push_beats(OP_LW, 32'h100, 32'h0);
    repeat (3) @(negedge clk);
    chk("rstmid_req_pre", 32'(bus8.mem_req_o), 32'd1);
    chk("rstmid_stall_pre", 32'(stall_o), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_req", 32'(bus8.mem_req_o), 32'd0);
    chk("rstmid_stall", 32'(stall_o), 32'd0);
    chk("rstmid_wreq", 32'(w_req_o), 32'd0);
    chk("rstmid_wdata", w_data_o, 32'd0);
    chk("rstmid_memaddr", bus8.mem_addr_o, 32'd0);
    valid_i = 1'b0;
    @(negedge clk);
    beat_q.delete();
    rst = 1'b1;
    run8('{OP_LB, 32'h100, 32'h0, 1'b1, 0, 32'h0000_0078, 1'b1}, "post_rst");

    run16(OP_LH,  32'h020, 32'h0,         32'hFFFF_8001, 2, "w16_lh");
    run16(OP_LHU, 32'h020, 32'h0,         32'h0000_8001, 2, "w16_lhu");
    run16(OP_LW,  32'h100, 32'h0,         32'h1234_5678, 3, "w16_lw");
    run16(OP_SB,  32'h030, 32'h1234_5678, 32'h0000_0078, 2, "w16_sb");
    run16(OP_SW,  32'h030, 32'h1234_5678, 32'h0000_5678, 3, "w16_sw");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
